// File: rtl/pixel_shuffle_ctrl.sv
// pixel_shuffle_ctrl: sequences one pixel_shuffle tile. It packs NPIX serial input
// pixels into in_buf, pulses ps_start, then waits for ps_done. The wait has a
// timeout guard that drops the tile on expiry. On done it captures the flat result
// into out_buf and streams it back out serially.
// Ports: clk/rst (async active-high); s_valid/s_data/s_ready for the input stream;
//        ps_start/ps_in_data_flat/ps_done/ps_out_data_flat connect to pixel_shuffle;
//        m_valid/m_data/m_last/m_ready for the output stream;
//        busy/timeout_err/frame_cnt report status.
module pixel_shuffle_ctrl #(
  parameter int C          = 1,
  parameter int R          = 2,
  parameter int H          = 2,
  parameter int W          = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255,
  localparam int NPIX      = C * R * R * H * W,
  localparam int CW        = (NPIX > 1) ? $clog2(NPIX) : 1,
  localparam int TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  input  logic [DATA_WIDTH-1:0]      s_data,
  output logic                       s_ready,
  output logic                       ps_start,
  output logic [NPIX*DATA_WIDTH-1:0] ps_in_data_flat,
  input  logic                       ps_done,
  input  logic [NPIX*DATA_WIDTH-1:0] ps_out_data_flat,
  output logic                       m_valid,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_last,
  input  logic                       m_ready,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [15:0]                frame_cnt
);

  typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_DRAIN} state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [NPIX*DATA_WIDTH-1:0] r_in_buf;
  logic [NPIX*DATA_WIDTH-1:0] r_out_buf;
  logic [CW-1:0]              r_in_cnt;
  logic [CW-1:0]              r_out_cnt;
  logic [TW-1:0]              r_timer;
  logic                       r_timeout_err;
  logic [15:0]                r_frame_cnt;

  logic w_in_last;
  logic w_out_last;
  logic w_timer_exp;

  assign w_in_last   = (r_in_cnt == CW'(NPIX - 1));
  assign w_out_last  = (r_out_cnt == CW'(NPIX - 1));
  assign w_timer_exp = (r_timer == TW'(TIMEOUT - 1));

  assign ps_in_data_flat = r_in_buf;
  assign m_data          = r_out_buf[r_out_cnt*DATA_WIDTH +: DATA_WIDTH];
  assign timeout_err     = r_timeout_err;
  assign frame_cnt       = r_frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    s_ready  = 1'b0;
    ps_start = 1'b0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    busy     = 1'b1;
    case (r_state)
      S_LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (s_valid && w_in_last) w_next = S_START;
      end
      S_START: begin
        ps_start = 1'b1;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a timer expiring in the same cycle
        if (ps_done)          w_next = S_DRAIN;
        else if (w_timer_exp) w_next = S_LOAD;
      end
      S_DRAIN: begin
        m_valid = 1'b1;
        m_last  = w_out_last;
        if (m_ready && w_out_last) w_next = S_LOAD;
      end
      default: w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_buf      <= '0;
      r_out_buf     <= '0;
      r_in_cnt      <= '0;
      r_out_cnt     <= '0;
      r_timer       <= '0;
      r_timeout_err <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (s_valid) begin
            r_in_buf[r_in_cnt*DATA_WIDTH +: DATA_WIDTH] <= s_data;
            r_in_cnt <= w_in_last ? '0 : r_in_cnt + 1'b1;
          end
        end
        S_START: begin
          r_timer       <= '0;
          r_timeout_err <= 1'b0;
        end
        S_WAIT: begin
          if (ps_done) begin
            r_out_buf <= ps_out_data_flat;
            r_out_cnt <= '0;
          end else if (w_timer_exp) begin
            // tile is abandoned; the next load restarts at slot 0
            r_timeout_err <= 1'b1;
            r_in_cnt      <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DRAIN: begin
          if (m_ready) begin
            r_out_cnt <= w_out_last ? '0 : r_out_cnt + 1'b1;
            if (w_out_last) r_frame_cnt <= r_frame_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_shuffle_ctrl.sv
module tb_pixel_shuffle_ctrl;
  localparam int C = 1, R = 2, H = 2, W = 2, DW = 8, TMO = 8;
  localparam int NPIX = C * R * R * H * W;
  localparam int FW = NPIX * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          ps_start;
  logic [FW-1:0] ps_in_data_flat;
  logic          ps_done;
  logic [FW-1:0] ps_out_data_flat;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic          busy;
  logic          timeout_err;
  logic [15:0]   frame_cnt;

  int n_cmp = 0, n_err = 0, n_start = 0, exp_starts = 0, exp_frames = 0;

  logic [DW-1:0] cur[NPIX];
  logic [FW-1:0] cur_flat, exp_flat;

  always #5 clk = ~clk;

  pixel_shuffle_ctrl #(
    .C(C), .R(R), .H(H), .W(W), .DATA_WIDTH(DW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .ps_start(ps_start), .ps_in_data_flat(ps_in_data_flat),
    .ps_done(ps_done), .ps_out_data_flat(ps_out_data_flat),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  // Pixel shuffle: out[c][oy][ox] = in[c*R*R + (oy%R)*R + ox%R][oy/R][ox/R]
  function automatic logic [FW-1:0] shuffle_flat(input logic [FW-1:0] f);
    logic [FW-1:0] o;
    int src, dst;
    o = '0;
    for (int c = 0; c < C; c++)
      for (int oy = 0; oy < H * R; oy++)
        for (int ox = 0; ox < W * R; ox++) begin
          dst = c * H * R * W * R + oy * W * R + ox;
          src = (c * R * R + (oy % R) * R + (ox % R)) * H * W + (oy / R) * W + (ox / R);
          o[dst*DW +: DW] = f[src*DW +: DW];
        end
    return o;
  endfunction

  // Stub pixel_shuffle: the result is only valid while ps_done is high,
  // so a capture on the wrong edge returns inverted data.
  assign ps_out_data_flat = ps_done ? shuffle_flat(ps_in_data_flat) : ~shuffle_flat(ps_in_data_flat);

  always @(posedge clk) if (ps_start) n_start <= n_start + 1;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_tile();
    for (int k = 0; k < NPIX; k++) begin
      cur[k] = DW'($urandom);
      cur_flat[k*DW +: DW] = cur[k];
    end
    exp_flat = shuffle_flat(cur_flat);
  endtask

  task automatic load_tile(input bit gaps, input bit spur);
    int i = 0, guard = 0;
    bit acc;
    while (i < NPIX && guard < 1000) begin
      @(negedge clk);
      guard++;
      chk("load_s_ready", s_ready, 1);
      chk("load_busy", busy, 0);
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = cur[i];
      ps_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      acc = s_valid;
      @(posedge clk);
      if (acc) i++;
    end
    chk("load_progress", i, NPIX);
  endtask

  task automatic do_start(input bit spur, input bit err_before);
    @(negedge clk);
    exp_starts++;
    chk("start_pulse", ps_start, 1);
    chk("start_busy", busy, 1);
    chk("start_s_ready", s_ready, 0);
    chk("start_in_flat", ps_in_data_flat, cur_flat);
    chk("start_err", timeout_err, err_before);
    // offered pixels must be ignored until the tile has drained
    s_valid = 1'b1;
    s_data  = 8'hEE;
    ps_done = spur;
  endtask

  // d = WAIT cycle on which ps_done is raised; d = 0 means never
  task automatic do_wait(input int d);
    int lim;
    lim = (d == 0) ? TMO : d;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      chk("wait_start_low", ps_start, 0);
      chk("wait_busy", busy, 1);
      chk("wait_s_ready", s_ready, 0);
      chk("wait_m_valid", m_valid, 0);
      chk("wait_err_clear", timeout_err, 0);
      chk("wait_in_stable", ps_in_data_flat, cur_flat);
      ps_done = (k == d);
    end
    @(negedge clk);
    ps_done = 1'b0;
    if (d == 0) begin
      s_valid = 1'b0;
      chk("tmo_err", timeout_err, 1);
      chk("tmo_s_ready", s_ready, 1);
      chk("tmo_busy", busy, 0);
      chk("tmo_frames", frame_cnt, exp_frames);
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: 3-cycle stalls at pixels 0, 7, 15
  task automatic do_drain(input int mode, input int abort_after);
    int idx = 0, guard = 0, stall = 0;
    bit rdy;
    while (idx < NPIX && guard < 1000) begin
      guard++;
      chk("drain_m_valid", m_valid, 1);
      chk("drain_m_data", m_data, exp_flat[idx*DW +: DW]);
      chk("drain_m_last", m_last, idx == NPIX - 1);
      chk("drain_s_ready", s_ready, 0);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          if ((idx == 0 || idx == 7 || idx == 15) && stall < 3) begin
            rdy = 1'b0;
            stall++;
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
      m_ready = rdy;
      @(posedge clk);
      if (rdy) begin
        idx++;
        stall = 0;
      end
      @(negedge clk);
      if (idx == abort_after) break;
    end
    m_ready = 1'b0;
    s_valid = 1'b0;
    if (abort_after < 0) begin
      exp_frames++;
      chk("drain_progress", idx, NPIX);
      chk("end_m_valid", m_valid, 0);
      chk("end_busy", busy, 0);
      chk("end_s_ready", s_ready, 1);
      chk("end_frames", frame_cnt, exp_frames);
    end
  endtask

  initial begin
    logic [DW-1:0] basic_seq[NPIX];
    basic_seq = '{1, 5, 2, 6, 9, 13, 10, 14, 3, 7, 4, 8, 11, 15, 12, 16};
    rst = 1'b1; s_valid = 1'b0; s_data = '0; ps_done = 1'b0; m_ready = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_ps_start", ps_start, 0);
    chk("rst_in_flat", ps_in_data_flat, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_frames", frame_cnt, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // basic tile 1..16 against the known shuffled order
    for (int k = 0; k < NPIX; k++) begin
      cur[k] = DW'(k + 1);
      cur_flat[k*DW +: DW] = cur[k];
      exp_flat[k*DW +: DW] = basic_seq[k];
    end
    load_tile(0, 0); do_start(0, 0); do_wait(3); do_drain(0, -1);
    chk("basic_one_start", n_start, 1);

    // input gaps and random output readiness
    new_tile(); load_tile(1, 0); do_start(0, 0); do_wait($urandom_range(1, TMO - 1)); do_drain(1, -1);

    // fixed backpressure stalls
    new_tile(); load_tile(1, 0); do_start(0, 0); do_wait(2); do_drain(2, -1);

    // timeout: done never arrives
    new_tile(); load_tile(0, 0); do_start(0, 0); do_wait(0);
    repeat (3) @(negedge clk);
    chk("tmo_err_sticky", timeout_err, 1);
    chk("tmo_frames_hold", frame_cnt, exp_frames);

    // done on the final WAIT cycle, stray done pulses in LOAD/START
    new_tile(); load_tile(1, 1); do_start(1, 1); do_wait(TMO); do_drain(1, -1);
    chk("boundary_err", timeout_err, 0);

    for (int t = 0; t < 4; t++) begin
      new_tile(); load_tile(1, 0); do_start(0, 0); do_wait($urandom_range(1, TMO)); do_drain(1, -1);
    end

    // reset in the middle of the drain
    new_tile(); load_tile(0, 0); do_start(0, 0); do_wait(1); do_drain(0, 5);
    rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_last", m_last, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ps_start", ps_start, 0);
    chk("mid_rst_frames", frame_cnt, 0);
    chk("mid_rst_in_flat", ps_in_data_flat, 0);
    chk("mid_rst_s_ready", s_ready, 1);
    exp_frames = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    new_tile(); load_tile(1, 0); do_start(0, 0); do_wait(4); do_drain(1, -1);
    chk("post_rst_frames", frame_cnt, 1);

    @(negedge clk);
    chk("start_pulse_total", n_start, exp_starts - 1 + 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_shuffle_ctrl.md
Name: pixel_shuffle_ctrl

Overview:
Sequencing controller for the pixel_shuffle datapath. It accepts a serial pixel stream over a valid/ready handshake and packs one full input tile into pixel_shuffle's flat input bus. It then pulses start, waits for done with a timeout guard, and captures the flat output. Finally it streams the output tile back out serially over valid/ready with a last marker.

Parameters:
C, 1, output channels of pixel_shuffle
R, 2, upscale factor
H, 2, input tile height
W, 2, input tile width
DATA_WIDTH, 8, bits per pixel
TIMEOUT, 255, max cycles in WAIT before abort (>=1)
Derived: NPIX = C*R*R*H*W (input count = output count); CW = clog2(NPIX); TW = clog2(TIMEOUT+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
s_valid  in  1  input pixel valid
s_data  in  DATA_WIDTH  input pixel, channel-major then row-major (flat slot order)
s_ready  out  1  controller accepts input
ps_start  out  1  one-cycle start pulse to pixel_shuffle
ps_in_data_flat  out  NPIX*DATA_WIDTH  packed input tile to pixel_shuffle
ps_done  in  1  pixel_shuffle done
ps_out_data_flat  in  NPIX*DATA_WIDTH  pixel_shuffle flat output
m_valid  out  1  output pixel valid
m_data  out  DATA_WIDTH  output pixel, slot i = ps_out_data_flat[i*DATA_WIDTH +: DATA_WIDTH]
m_last  out  1  high with final pixel of tile
m_ready  in  1  downstream accepts output
busy  out  1  high in START/WAIT/DRAIN
timeout_err  out  1  sticky abort flag
frame_cnt  out  16  completed tiles, wraps at 0xFFFF

Behaviour:
- States: LOAD, START, WAIT, DRAIN. Reset state is LOAD.
- Reset (async, rst=1): all registers are 0, including in_buf, out_buf, counters, timeout_err and frame_cnt. ps_start, m_valid, m_last and busy are 0. No transfer counts while rst=1.
- s_ready = (state==LOAD). m_valid = (state==DRAIN). busy = (state!=LOAD).
- ps_in_data_flat is driven directly from the registered in_buf.
- LOAD:
  - On s_valid & s_ready: in_buf slot in_cnt <= s_data, then in_cnt++.
  - On acceptance of slot NPIX-1: in_cnt <= 0, go to START.
  - Partial tiles stay in LOAD indefinitely.
- START:
  - ps_start=1 for exactly this one cycle.
  - timer <= 0 and timeout_err <= 0.
  - Next state is WAIT.
  - ps_done in this cycle is ignored.
- WAIT:
  - ps_start=0. in_buf is held stable.
  - If ps_done=1: out_buf <= ps_out_data_flat (same edge), out_cnt <= 0, go to DRAIN.
  - Else if timer==TIMEOUT-1: timeout_err <= 1, in_cnt <= 0, go to LOAD. The tile is discarded and frame_cnt is unchanged.
  - Else timer++.
  - If ps_done arrives on the cycle the timer expires, done wins.
  - WAIT latency is 1..TIMEOUT cycles.
- DRAIN:
  - m_data = out_buf slot out_cnt. m_last = (out_cnt==NPIX-1).
  - On m_valid & m_ready: out_cnt++.
  - On the last transfer: frame_cnt++, go to LOAD.
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
  - ps_done is ignored outside WAIT.
- Throughput per tile: NPIX input cycles + 1 START cycle + pixel_shuffle latency + NPIX output cycles, with no overlap (single buffer).
- Reset mid-operation: immediate return to LOAD with all state cleared. A partial output tile is lost with no m_last.
- timeout_err is cleared only by the next START or by reset.

Test Plan:
- Basic tile: connect real pixel_shuffle (C=1,R=2,H=W=2). Stream s_data=1..16 with s_valid held high -> exactly one ps_start pulse the cycle after pixel 16, ps_in_data_flat slot i = i+1. m_data sequence = 1,5,2,6,9,13,10,14,3,7,4,8,11,15,12,16 with m_last only on 16. frame_cnt=1, busy returns to 0.
- Input gaps: s_valid toggled randomly during LOAD -> identical output and ps_in_data_flat. s_ready=0 from START until the end of DRAIN.
- Output backpressure: m_ready low for 3 cycles at each of pixels 0, 7 and 15 -> m_data/m_last held stable. Sequence unchanged, no duplicates or drops.
- Timeout: stub never asserts ps_done, TIMEOUT=8 -> 8 cycles in WAIT, then timeout_err=1, s_ready=1, frame_cnt=0. On the next full tile with a working done, timeout_err clears at START.
- Done on the boundary: stub asserts ps_done exactly on the TIMEOUT-th WAIT cycle -> DRAIN taken, timeout_err=0. ps_done pulse during LOAD/START -> ignored.
- Reset mid-DRAIN: assert rst after 5 output pixels -> all outputs 0 asynchronously. After release, s_ready=1, frame_cnt=0, and the next tile is processed correctly from slot 0.
